// File: rtl/harvard_pkg.sv
// harvard_pkg: shared widths, instruction field slices, HALT opcode and fetch state encoding
package harvard_pkg;
  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 16;
  localparam int INSTR_W   = 22;
  localparam int OPC_MSB   = 21;
  localparam int OPC_LSB   = 17;
  localparam int AM_BIT    = 16;
  localparam int OPR_MSB   = 15;
  localparam int OPR_LSB   = 0;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b11111;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry word+pc buffer; ports clk/rst_n, load/unload/clear, data_in/pc_in -> full/data_out/pc_out
module fetch_hold_buffer
  import harvard_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                unload,
  input  logic                clear,
  input  logic [INSTR_W-1:0]  data_in,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                full,
  output logic [INSTR_W-1:0]  data_out,
  output logic [PC_WIDTH-1:0] pc_out
);
  logic full_q, full_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  always_comb begin
    full_d = clear ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : full_q;
    data_d = load ? data_in : data_q;
    pc_d   = load ? pc_in : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end
  assign full     = full_q;
  assign data_out = data_q;
  assign pc_out   = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC + imem req/valid fetch FSM feeding the decoder, with stall, branch redirect and HALT
// Ports: ClockInput/ResetInput (sync, active-low); Imem{Req,Addr}Output, Imem{Data,Valid}Input;
// StallInput, BranchTakenInput/BranchTargetInput; decoder fields, FetchValidOutput, PcOutput, HaltedOutput.
module instruction_fetch #(
  parameter int                             PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0]            RESET_PC    = '0,
  parameter logic [harvard_pkg::OPCODE_W-1:0] HALT_OPCODE = harvard_pkg::HALT_OPCODE
) (
  input  logic                              ClockInput,
  input  logic                              ResetInput,
  output logic                              ImemReqOutput,
  output logic [PC_WIDTH-1:0]               ImemAddrOutput,
  input  logic [harvard_pkg::INSTR_W-1:0]   ImemDataInput,
  input  logic                              ImemValidInput,
  input  logic                              StallInput,
  input  logic                              BranchTakenInput,
  input  logic [PC_WIDTH-1:0]               BranchTargetInput,
  output logic [harvard_pkg::OPCODE_W-1:0]  OpecodeOutput,
  output logic                              AddressingModeOutput,
  output logic [harvard_pkg::OPERAND_W-1:0] OperandOutput,
  output logic                              FetchValidOutput,
  output logic [PC_WIDTH-1:0]               PcOutput,
  output logic                              HaltedOutput
);
  import harvard_pkg::*;
  fetch_state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, out_pc_q, out_pc_d, word_pc, buf_pc;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic [OPERAND_W-1:0] opr_q, opr_d;
  logic [INSTR_W-1:0] word, buf_data;
  logic am_q, am_d, fv_q, fv_d;
  logic consumed, slot_free, branch, load_out, buf_load, buf_unload, buf_clear, buf_full;
  assign consumed  = fv_q & ~StallInput;
  assign slot_free = ~fv_q | consumed;
  assign branch    = BranchTakenInput & (state_q != IDLE);
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fv_d       = consumed ? 1'b0 : fv_q;
    load_out   = 1'b0;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_clear  = 1'b0;
    word       = ImemDataInput;
    word_pc    = pc_q;
    if (branch) begin
      pc_d      = BranchTargetInput;
      fv_d      = 1'b0;
      buf_clear = 1'b1;
      // a read still in flight must be drained before the next request
      state_d   = ((state_q == WAIT || state_q == DRAIN) && !ImemValidInput) ? DRAIN : REQ;
    end else begin
      case (state_q)
        IDLE:  state_d = REQ;
        REQ:   state_d = WAIT;
        WAIT:  if (ImemValidInput) begin
                 load_out = slot_free;
                 buf_load = ~slot_free;
                 state_d  = slot_free ? state_q : HOLD;
               end
        HOLD:  if (buf_full && slot_free) begin
                 load_out   = 1'b1;
                 buf_unload = 1'b1;
                 word       = buf_data;
                 word_pc    = buf_pc;
               end
        DRAIN: state_d = ImemValidInput ? REQ : DRAIN;
        default: state_d = state_q;
      endcase
      if (load_out) begin
        fv_d    = 1'b1;
        pc_d    = pc_q + 1'b1;
        state_d = (word[OPC_MSB:OPC_LSB] == HALT_OPCODE) ? HALTED : REQ;
      end
    end
    opc_d    = load_out ? word[OPC_MSB:OPC_LSB] : opc_q;
    am_d     = load_out ? word[AM_BIT] : am_q;
    opr_d    = load_out ? word[OPR_MSB:OPR_LSB] : opr_q;
    out_pc_d = load_out ? word_pc : out_pc_q;
  end
  always_ff @(posedge ClockInput) begin
    if (!ResetInput) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      fv_q     <= 1'b0;
      opc_q    <= '0;
      am_q     <= 1'b0;
      opr_q    <= '0;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fv_q     <= fv_d;
      opc_q    <= opc_d;
      am_q     <= am_d;
      opr_q    <= opr_d;
      out_pc_q <= out_pc_d;
    end
  end
  fetch_hold_buffer #(.PC_WIDTH(PC_WIDTH)) u_buf (
    .clk(ClockInput),
    .rst_n(ResetInput),
    .load(buf_load),
    .unload(buf_unload),
    .clear(buf_clear),
    .data_in(ImemDataInput),
    .pc_in(pc_q),
    .full(buf_full),
    .data_out(buf_data),
    .pc_out(buf_pc)
  );
  assign ImemReqOutput        = state_q == REQ;
  assign ImemAddrOutput       = ImemReqOutput ? pc_q : '0;
  assign HaltedOutput         = state_q == HALTED;
  assign OpecodeOutput        = opc_q;
  assign AddressingModeOutput = am_q;
  assign OperandOutput        = opr_q;
  assign FetchValidOutput     = fv_q;
  assign PcOutput             = out_pc_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench with a variable-latency instruction memory model
module tb_instruction_fetch;
  typedef struct packed {logic [7:0] pc; logic [21:0] w;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req, valid, stall, branch, fv, halted, am;
  logic [7:0] addr, target, pc_out;
  logic [21:0] data;
  logic [4:0] opc;
  logic [15:0] opr;
  logic req_w, valid_w, fv_w, halted_w, am_w, req_d1;
  logic [7:0] addr_w, pc_w, addr_d1;
  logic [21:0] data_w;
  logic [4:0] opc_w;
  logic [15:0] opr_w;
  logic [21:0] rom [256];
  logic [7:0] log_w [2];
  exp_t q[$];
  exp_t e;
  int lat, cnt, n_cmp, n_err, n_cons, cyc, last_cons_cyc, nreq_w;
  logic pend, abandon;
  logic [7:0] m_addr;
  instruction_fetch dut (
    .ClockInput(clk), .ResetInput(rst_n),
    .ImemReqOutput(req), .ImemAddrOutput(addr), .ImemDataInput(data), .ImemValidInput(valid),
    .StallInput(stall), .BranchTakenInput(branch), .BranchTargetInput(target),
    .OpecodeOutput(opc), .AddressingModeOutput(am), .OperandOutput(opr),
    .FetchValidOutput(fv), .PcOutput(pc_out), .HaltedOutput(halted)
  );
  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'hFF)) dut_w (
    .ClockInput(clk), .ResetInput(rst_n),
    .ImemReqOutput(req_w), .ImemAddrOutput(addr_w), .ImemDataInput(data_w), .ImemValidInput(valid_w),
    .StallInput(1'b0), .BranchTakenInput(1'b0), .BranchTargetInput(8'h00),
    .OpecodeOutput(opc_w), .AddressingModeOutput(am_w), .OperandOutput(opr_w),
    .FetchValidOutput(fv_w), .PcOutput(pc_w), .HaltedOutput(halted_w)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // memory model, scoreboard push on delivery, scoreboard pop on consume
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pend = 1'b0;
      valid = 1'b0;
      abandon = 1'b0;
    end else begin
      if (fv && !stall && !branch) begin
        check("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_pc", pc_out, e.pc);
          check("sb_opc", opc, e.w[21:17]);
          check("sb_am", am, e.w[16]);
          check("sb_opr", opr, e.w[15:0]);
          n_cons++;
          last_cons_cyc = cyc;
        end
      end
      if (branch) q.delete();
      valid = 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          valid = 1'b1;
          data = rom[m_addr];
          if (!abandon && !branch) q.push_back({m_addr, rom[m_addr]});
          pend = 1'b0;
          abandon = 1'b0;
        end else begin
          cnt--;
          if (branch) abandon = 1'b1;
        end
      end
      if (req) begin
        check("one_outstanding", pend, 0);
        pend = 1'b1;
        cnt = lat;
        m_addr = addr;
        abandon = 1'b0;
      end
    end
  end
  // fixed 1-cycle memory for the wrap instance
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_w = 1'b0;
      req_d1 = 1'b0;
      nreq_w = 0;
    end else begin
      valid_w = req_d1;
      if (req_d1) data_w = rom[addr_d1];
      req_d1 = req_w;
      addr_d1 = addr_w;
      if (req_w && nreq_w < 2) begin
        log_w[nreq_w] = addr_w;
        nreq_w++;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    branch = 1'b0;
    stall = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic wait_cons(input int goal, input int bound, input string tag);
    for (int k = 0; k < bound && n_cons < goal; k++) tick;
    check(tag, n_cons >= goal, 1);
  endtask
  initial begin
    int c0, nr;
    for (int i = 0; i < 256; i++) rom[i] = {5'h04, i[0], 16'h1000 + 16'(i)};
    rom[0] = {5'h01, 1'b0, 16'h0010};
    rom[1] = {5'h02, 1'b1, 16'h0020};
    rom[2] = {5'h03, 1'b0, 16'h0030};
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 8'h00; valid = 1'b0; data = '0;
    valid_w = 1'b0; data_w = '0; lat = 1;
    tick;
    tick;
    @(negedge clk);
    check("rst_req", req, 0);
    check("rst_addr", addr, 0);
    check("rst_fv", fv, 0);
    check("rst_pc", pc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_opc", opc, 0);
    check("rst_am", am, 0);
    check("rst_opr", opr, 0);
    // 1: straight-line fetch, one instruction per two cycles
    do_reset;
    c0 = cyc;
    wait_cons(n_cons + 3, 20, "t1_count");
    check("t1_rate", last_cons_cyc - c0, 7);
    // 2: stall while next word returns
    do_reset;
    for (int k = 0; k < 10 && !fv; k++) tick;
    stall = 1'b1;
    tick;
    tick;
    repeat (3) begin
      @(negedge clk);
      check("t2_noreq", req, 0);
      check("t2_pc", pc_out, 0);
      check("t2_fv", fv, 1);
    end
    tick;
    stall = 1'b0;
    tick;
    @(negedge clk);
    check("t2_pc1", pc_out, 1);
    check("t2_opc1", opc, 5'h02);
    check("t2_fv1", fv, 1);
    wait_cons(n_cons + 2, 20, "t2_cons");
    // 3: branch during WAIT with 3-cycle memory
    lat = 3;
    do_reset;
    tick;
    tick;
    branch = 1'b1;
    target = 8'h40;
    tick;
    branch = 1'b0;
    @(negedge clk);
    check("t3_flush", fv, 0);
    check("t3_noreq", req, 0);
    for (int k = 0; k < 10 && !req; k++) @(negedge clk);
    check("t3_req_seen", req, 1);
    check("t3_addr", addr, 8'h40);
    wait_cons(n_cons + 2, 40, "t3_cons");
    // 4: branch coincident with valid
    lat = 1;
    do_reset;
    tick;
    tick;
    branch = 1'b1;
    target = 8'h80;
    tick;
    branch = 1'b0;
    @(negedge clk);
    check("t4_req", req, 1);
    check("t4_addr", addr, 8'h80);
    check("t4_fv", fv, 0);
    wait_cons(n_cons + 2, 20, "t4_cons");
    // 5: HALT parks the unit, branch restarts it
    rom[2] = {5'h1F, 1'b0, 16'h0BAD};
    do_reset;
    for (int k = 0; k < 20 && !(fv && pc_out == 8'h02); k++) tick;
    check("t5_pc", pc_out, 2);
    check("t5_opc", opc, 5'h1F);
    check("t5_halted", halted, 1);
    nr = 0;
    repeat (6) begin
      @(negedge clk);
      nr += int'(req);
    end
    check("t5_noreq", nr, 0);
    check("t5_drained", fv, 0);
    tick;
    branch = 1'b1;
    target = 8'h00;
    tick;
    branch = 1'b0;
    @(negedge clk);
    check("t5_unhalt", halted, 0);
    check("t5_req", req, 1);
    check("t5_addr", addr, 0);
    wait_cons(n_cons + 3, 20, "t5_cons");
    rom[2] = {5'h03, 1'b0, 16'h0030};
    // 6: wrap from RESET_PC=FF
    do_reset;
    tick;
    tick;
    tick;
    @(negedge clk);
    check("t6_fv", fv_w, 1);
    check("t6_pc_ff", pc_w, 8'hFF);
    tick;
    tick;
    @(negedge clk);
    check("t6_pc_00", pc_w, 8'h00);
    check("t6_addr0", log_w[0], 8'hFF);
    check("t6_addr1", log_w[1], 8'h00);
    // 6b: reset mid-WAIT beats branch
    lat = 3;
    do_reset;
    for (int k = 0; k < 15 && !fv; k++) tick;
    stall = 1'b1;
    tick;
    rst_n = 1'b0;
    branch = 1'b1;
    target = 8'h33;
    tick;
    branch = 1'b0;
    stall = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("r_req", req, 0);
    check("r_addr", addr, 0);
    check("r_fv", fv, 0);
    check("r_pc", pc_out, 0);
    check("r_opc", opc, 0);
    check("r_am", am, 0);
    check("r_opr", opr, 0);
    check("r_halted", halted, 0);
    tick;
    @(negedge clk);
    check("r_req_after", req, 1);
    check("r_addr_after", addr, 0);
    wait_cons(n_cons + 1, 30, "r_cons");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
